alu_arbiter: RTL and testbench



---
 rtl/alu_pkg.sv | 10 +
 rtl/alu_arb_grant.sv | 17 +
 rtl/alu_arbiter.sv | 96 +++++++++
 tb/tb_alu_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, arbiter FSM states and the opcode set understood by alu
package alu_pkg;
  localparam int DATA_W = 8;
  localparam int OP_W = 4;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'h0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR,
    OP_INC, OP_DEC, OP_PASS_A, OP_PASS_B
  } alu_op_t;
endpackage

// File: rtl/alu_arb_grant.sv
// alu_arb_grant: picks requester 0 or 1; ALU_ARB_RR_EN selects round-robin, else fixed priority to 0
module alu_arb_grant (
  input  logic v0,
  input  logic v1,
  input  logic last_grant,
  output logic grant,
  output logic any_valid
);
  assign any_valid = v0 || v1;
`ifdef ALU_ARB_RR_EN
  assign grant = (v0 && v1) ? !last_grant : v1;
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant = v1 && !v0;
`endif
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational alu between two valid/ready clients; IDLE -> EXEC -> RESP
// ALU_ARB_RR_EN enables round-robin tie breaking (otherwise requester 0 always wins ties)
module alu_arbiter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_sl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_sl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_sl,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_s,
  input  logic              alu_p,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_c,
  output logic              rsp_z,
  output logic              rsp_s,
  output logic              rsp_p,
  output logic              busy
);
  arb_state_t state;
  logic grant, any_valid, last_grant;
  alu_arb_grant u_grant (
    .v0(req0_valid),
    .v1(req1_valid),
    .last_grant(last_grant),
    .grant(grant),
    .any_valid(any_valid)
  );
`ifndef ALU_ARB_RR_EN
  assign last_grant = 1'b1;
`endif
  // readys are forced low while reset is asserted so every output shows its reset value
  assign req0_ready = rst_n && state == IDLE && !grant && req0_valid;
  assign req1_ready = rst_n && state == IDLE && grant && req1_valid;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
`ifdef ALU_ARB_RR_EN
      last_grant <= 1'b1;
`endif
      alu_a <= '0;
      alu_b <= '0;
      alu_sl <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_out <= '0;
      rsp_c <= 1'b0;
      rsp_z <= 1'b0;
      rsp_s <= 1'b0;
      rsp_p <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (any_valid) begin
          state <= EXEC;
          alu_a <= grant ? req1_a : req0_a;
          alu_b <= grant ? req1_b : req0_b;
          alu_sl <= grant ? req1_sl : req0_sl;
          rsp_id <= grant;
`ifdef ALU_ARB_RR_EN
          last_grant <= grant;
`endif
        end
        EXEC: begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_out <= alu_out;
          rsp_c <= alu_c;
          rsp_z <= alu_z;
          rsp_s <= alu_s;
          rsp_p <= alu_p;
        end
        RESP: if (rsp_ready) begin
          state <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter against a constant alu stub (Out=5F, C=1, Z=0, S=0, P=1)
module tb_alu_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0] req0_sl = '0, req1_sl = '0;
  logic [7:0] alu_a, alu_b, rsp_out;
  logic [3:0] alu_sl;
  logic rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_c, rsp_z, rsp_s, rsp_p, busy;
  int checks = 0, errors = 0;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sl(req0_sl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sl(req1_sl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sl(alu_sl),
    .alu_out(8'h5F), .alu_c(1'b1), .alu_z(1'b0), .alu_s(1'b0), .alu_p(1'b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
    .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_s(rsp_s), .rsp_p(rsp_p), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rdy0"}, req0_ready, 0);
    check({tag, "_rdy1"}, req1_ready, 0);
  endtask

  initial begin
    #2;
    check_idle_outputs("reset");
    check("reset_alu", {alu_a, alu_b, alu_sl}, 0);
    check("reset_rsp", {rsp_id, rsp_out, rsp_c, rsp_z, rsp_s, rsp_p}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    // single op
    req0_valid = 1'b1; req0_a = 8'hF8; req0_b = 8'h67; req0_sl = 4'h0;
    #1;
    check("single_rdy0", req0_ready, 1);
    check("single_rdy1", req1_ready, 0);
    check("single_busy_idle", busy, 0);
    tick();
    check("single_busy_exec", busy, 1);
    check("single_rdy0_exec", req0_ready, 0);
    check("single_alu", {alu_a, alu_b, alu_sl}, {8'hF8, 8'h67, 4'h0});
    check("single_rsp_valid_exec", rsp_valid, 0);
    req0_valid = 1'b0;
    tick();
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rsp_id", rsp_id, 0);
    check("single_rsp_out", rsp_out, 8'h5F);
    check("single_flags", {rsp_c, rsp_z, rsp_s, rsp_p}, 4'b1001);
    tick();
    check_idle_outputs("single_done");
    // tie sequence from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_sl = 4'h1;
    req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44; req1_sl = 4'h2;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic exp_g;
      exp_g = RR ? 1'(i % 2) : 1'b0;
      check("tie_rdy0", req0_ready, !exp_g);
      check("tie_rdy1", req1_ready, exp_g);
      tick();
      check("tie_alu_a", alu_a, exp_g ? 8'h33 : 8'h11);
      tick();
      check("tie_rsp_id", rsp_id, exp_g);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    // backpressure
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h12; req1_b = 8'h34; req1_sl = 4'h3;
    #1;
    check("bp_rdy1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h9A; req0_b = 8'hBC; req0_sl = 4'h4;
    #1;
    check("bp_rdy0_exec", req0_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp", {rsp_id, rsp_out, rsp_c, rsp_z, rsp_s, rsp_p}, {1'b1, 8'h5F, 4'b1001});
      check("bp_rdys", {req0_ready, req1_ready}, 0);
      check("bp_busy", busy, 1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_rsp_valid_release", rsp_valid, 1);
    tick();
    check("bp_next_rdy0", req0_ready, 1);
    check("bp_next_rsp_valid", rsp_valid, 0);
    tick();
    check("bp_next_alu", {alu_a, alu_b, alu_sl}, {8'h9A, 8'hBC, 4'h4});
    req0_valid = 1'b0;
    tick();
    check("bp_next_rsp_id", rsp_id, 0);
    tick();
    // late arrival
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_sl = 4'h1;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h55; req1_sl = 4'h2;
    #1;
    check("late_rdy1_exec", req1_ready, 0);
    tick();
    check("late_rdy1_resp", req1_ready, 0);
    check("late_rsp_id0", rsp_id, 0);
    tick();
    check("late_rdy1_idle", req1_ready, 1);
    tick();
    check("late_alu", {alu_a, alu_b, alu_sl}, {8'hAA, 8'h55, 4'h2});
    req1_valid = 1'b0;
    tick();
    check("late_rsp_id1", rsp_id, 1);
    tick();
    // reset during EXEC
    req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'hC3; req0_sl = 4'h5;
    tick();
    check("rst_exec_alu_a", alu_a, 8'h3C);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    check("rst_mid_alu", {alu_a, alu_b, alu_sl}, 0);
    check("rst_mid_rsp", {rsp_id, rsp_out, rsp_c, rsp_z, rsp_s, rsp_p}, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_rdy0_again", req0_ready, 1);
    tick();
    check("rst_alu_again", {alu_a, alu_b, alu_sl}, {8'h3C, 8'hC3, 4'h5});
    req0_valid = 1'b0;
    tick();
    check("rst_rsp_valid", rsp_valid, 1);
    check("rst_rsp", {rsp_id, rsp_out, rsp_c, rsp_z, rsp_s, rsp_p}, {1'b0, 8'h5F, 4'b1001});
    tick();
    // idle hold
    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle_outputs("idle");
      check("idle_alu_hold", {alu_a, alu_b, alu_sl}, {8'h3C, 8'hC3, 4'h5});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
